shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Command sequencer for the team's 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake and preloads the register with a parallel word. It then issues the requested shift/rotate/serial mode for a programmed number of cycles, captures the register's parallel output and returns it over a valid/ready response channel. It sits between a host/bus-side requester and the shift-register datapath, which it drives through the `sr_*` ports.

## Interface
- `WIDTH`, 4: shift-register data width.
- `CNT_W`, 3: width of the cycle-count field.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command (IDLE only).
- `cmd_op` input 3: mode code (100 shl, 101 shr, 110 rotl, 111 rotr, 000 SISO, 001 SIPO, 010 PISO, 011 PIPO).
- `cmd_cnt` input CNT_W: number of RUN cycles. 0 means preload only.
- `cmd_din` input WIDTH: preload word.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: requester takes result.
- `rsp_data` output WIDTH: captured register contents.
- `busy` output 1: high in every state except IDLE.
- `sr_load` output 1: enable to shift register.
- `sr_sel` output 3: mode select to shift register.
- `sr_din` output WIDTH: parallel word to shift register.
- `sr_data` output 1: serial input to shift register.
- `sr_dout` input WIDTH: shift-register parallel output (registered in datapath).
- `ser_in` input 1: external serial stream, forwarded in RUN.

## Operation
- FSM states: IDLE, LOAD, RUN, CAPT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid&&cmd_ready`, latch op, cnt and din, then go to LOAD.
- LOAD (1 cycle):
  - `sr_load`=1, `sr_sel`=011 (PIPO), `sr_din`=latched din.
  - Next state is RUN if cnt≠0 and op≠011; otherwise CAPT.
- RUN (cnt cycles):
  - `sr_load`=1, `sr_sel`=latched op, `sr_din`=latched din.
  - `sr_data`=`ser_in` (combinational pass-through, RUN only).
  - Down-counter is loaded with cnt on entry and decrements each cycle. Leave to CAPT when counter==1.
- CAPT (1 cycle): `sr_load`=0. Register `sr_dout` into `rsp_data` at end of cycle, then go to RESP.
- RESP: `rsp_valid`=1 with `rsp_data` held stable until `rsp_valid&&rsp_ready`, then go to IDLE.
- Outside LOAD/RUN: `sr_load`=0, `sr_sel`=000, `sr_data`=0. `sr_din` holds the last latched value.
- `cmd_*` inputs are ignored when `cmd_ready`=0. Latched fields never change mid-command.
- Counter is CNT_W bits with no wrap: max RUN length is 2^CNT_W−1 cycles (7 at default).
- Reset (any state, including mid-RUN or RESP):
  - Go to IDLE, counter=0, `rsp_data`=0.
  - Outputs: `rsp_valid`=0, `busy`=0, `sr_load`=0, `sr_sel`=000, `sr_din`=0, `sr_data`=0, `cmd_ready`=1 in the first cycle after reset.
  - A pending response is discarded.

## Timing
- All outputs except `sr_data` and `cmd_ready` are registered / decoded from the state register. `cmd_ready` is a pure decode of IDLE.
- Cycle numbering: command accepted on edge E0.
  - LOAD occupies cycle 1.
  - RUN occupies cycles 2..N+1 (N=cnt).
  - CAPT occupies cycle N+2.
  - `rsp_valid` rises at cycle N+3.
- Total accept-to-`rsp_valid` latency is N+3 cycles, or 3 when RUN is skipped.
- Response accepted on edge R puts the controller in IDLE for cycle R+1 (`cmd_ready`=1). A new command can be accepted no earlier than edge R+1.
- Back-to-back throughput: one command per N+4 cycles with `rsp_ready` tied high.
- `rsp_ready` high before `rsp_valid` has no effect.

## Test plan
- Reset check: assert `rst` for 2 cycles → all outputs at the reset values above and `cmd_ready`=1. Repeat `rst` mid-RUN (op=100, cnt=5, cycle 4) → IDLE next cycle, no `rsp_valid`.
- PIPO: op=011, din=1010, cnt=5 → one LOAD cycle (`sr_sel`=011), no RUN. `rsp_valid` at cycle 3 with `rsp_data`=1010 (bench shift-register model attached).
- ROTL: op=110, din=1001, cnt=1 → LOAD, then one RUN cycle with `sr_sel`=110. `rsp_data`=0011 at cycle 4. Same with op=111, cnt=2 → `rsp_data`=0110 at cycle 5.
- Backpressure: op=100, din=0001, cnt=2 with `rsp_ready`=0 for 6 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, and a new `cmd_valid` is ignored. Release `rsp_ready` → IDLE next cycle.
- Serial forwarding: op=001, cnt=4, `ser_in`=1,0,1,1 over cycles 2–5 → `sr_data` mirrors `ser_in` exactly in those cycles and is 0 elsewhere. `sr_load`=1 in cycles 1–5 only.
- Max count and back-to-back: cnt=7 → exactly 7 RUN cycles and `rsp_valid` at cycle 10. Second command issued with `rsp_ready` high is accepted at the first IDLE cycle, N+4 cycles after the first accept.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 4-bit universal shift register: preload, run a
// shift/rotate/serial mode for a programmed cycle count, capture and return the result.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_din,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             sr_load,
  output logic [2:0]       sr_sel,
  output logic [WIDTH-1:0] sr_din,
  output logic             sr_data,
  input  logic [WIDTH-1:0] sr_dout,
  input  logic             ser_in
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;

  localparam logic [2:0] OP_PIPO = 3'b011;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ctr;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] rsp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      cnt_q <= '0;
      din_q <= '0;
      ctr   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        cnt_q <= cmd_cnt;
        din_q <= cmd_din;
      end
      // Counter is armed during LOAD so it holds cnt on the first RUN cycle.
      if (state == LOAD)
        ctr <= cnt_q;
      else if (state == RUN)
        ctr <= ctr - CNT_W'(1);
      if (state == CAPT)
        rsp_q <= sr_dout;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = LOAD;
      LOAD:    state_nxt = (cnt_q != '0 && op_q != OP_PIPO) ? RUN : CAPT;
      RUN:     if (ctr == CNT_W'(1)) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    sr_load   = 1'b0;
    sr_sel    = '0;
    sr_data   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: begin
        sr_load = 1'b1;
        sr_sel  = OP_PIPO;
      end
      RUN: begin
        sr_load = 1'b1;
        sr_sel  = op_q;
        sr_data = ser_in;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign sr_din   = din_q;
  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural universal shift
// register attached; results are scoreboarded against a reference function.
module tb_shift_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_din;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             sr_load;
  logic [2:0]       sr_sel;
  logic [WIDTH-1:0] sr_din;
  logic             sr_data;
  logic [WIDTH-1:0] sr_dout;
  logic             ser_in;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_cnt(cmd_cnt), .cmd_din(cmd_din),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .sr_load(sr_load), .sr_sel(sr_sel), .sr_din(sr_din),
    .sr_data(sr_data), .sr_dout(sr_dout), .ser_in(ser_in)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural universal shift register (serial modes shift in at the LSB)
  logic [WIDTH-1:0] sr_q = '0;
  always @(posedge clk) begin
    if (sr_load) begin
      case (sr_sel)
        3'b100: sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        3'b101: sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        3'b110: sr_q <= {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
        3'b111: sr_q <= {sr_q[0], sr_q[WIDTH-1:1]};
        3'b010: sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        3'b011: sr_q <= sr_din;
        default: sr_q <= {sr_q[WIDTH-2:0], sr_data};
      endcase
    end
  end
  assign sr_dout = sr_q;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [WIDTH-1:0] exp_q[$];
  int unsigned last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op,
      input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] din, input logic [7:0] ser);
    logic [WIDTH-1:0] v;
    v = din;
    if (op == 3'b011) return din;
    for (int i = 0; i < int'(cnt); i++) begin
      case (op)
        3'b100:  v = v << 1;
        3'b101:  v = v >> 1;
        3'b110:  v = (v << 1) | (v >> (WIDTH - 1));
        3'b111:  v = (v >> 1) | (v << (WIDTH - 1));
        3'b010:  v = v << 1;
        default: v = (v << 1) | {{(WIDTH-1){1'b0}}, ser[i]};
      endcase
    end
    return v;
  endfunction

  // Called at a negedge (+1); returns at a negedge (+1) in the IDLE cycle after the response.
  task automatic do_cmd(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] din, input logic [7:0] ser,
                        input int unsigned hold, input bit early);
    int unsigned n_run, k, w;
    bit got_valid;
    logic exp_sd;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_din = din; rsp_ready = early;
    last_acc = cyc;
    exp_q.push_back(ref_result(op, cnt, din, ser));
    n_run = (cnt == '0 || op == 3'b011) ? 0 : int'(cnt);
    @(posedge clk);
    k = 0; got_valid = 0;
    while (!got_valid && k < 20) begin
      @(negedge clk); k++;
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_op = ~op; cmd_cnt = ~cnt; cmd_din = ~din;
      end
      ser_in = (k >= 2 && k <= n_run + 1) ? ser[k-2] : 1'b1;
      #1;
      if (rsp_valid) got_valid = 1;
      else begin
        exp_sd = (k >= 2 && k <= n_run + 1) ? ser_in : 1'b0;
        check("sr_load", sr_load, k <= n_run + 1);
        check("sr_sel", sr_sel, (k == 1) ? 3'b011 : ((k <= n_run + 1) ? op : 3'b000));
        check("sr_data", sr_data, exp_sd);
        check("sr_din", sr_din, din);
        check("busy", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
      end
    end
    check("rsp_latency", got_valid ? k : 0, n_run + 3);
    if (!got_valid) return;
    for (int h = 0; h < int'(hold); h++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_q.size() > 0 ? exp_q[0] : '0);
      check("bp_cmd_ready", cmd_ready, 0);
      cmd_valid = 1'b1; cmd_op = 3'($urandom_range(7)); cmd_din = 4'($urandom);
      cmd_cnt = 3'($urandom_range(7));
      @(negedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("rsp_valid", rsp_valid, 1);
    if (exp_q.size() == 0) check("sb_empty", 0, 1);
    else check("rsp_data", rsp_data, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    ser_in = 1'b1;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_sr_load", sr_load, 0);
    check("idle_sr_sel", sr_sel, 0);
    check("idle_sr_data", sr_data, 0);
    check("idle_sr_din", sr_din, din);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_sr_load"}, sr_load, 0);
    check({pfx, "_sr_sel"}, sr_sel, 0);
    check({pfx, "_sr_din"}, sr_din, 0);
    check({pfx, "_sr_data"}, sr_data, 0);
    check({pfx, "_rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    int unsigned a1;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_din = '0;
    rsp_ready = 1'b0; ser_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    do_cmd(3'b011, 3'd5, 4'b1010, 8'h00, 0, 0);   // PIPO: no RUN
    do_cmd(3'b110, 3'd1, 4'b1001, 8'h00, 0, 0);   // ROTL -> 0011
    do_cmd(3'b111, 3'd2, 4'b1001, 8'h00, 0, 0);   // ROTR -> 0110
    do_cmd(3'b100, 3'd2, 4'b0001, 8'h00, 6, 0);   // backpressure + stray cmd
    do_cmd(3'b001, 3'd4, 4'b0000, 8'b0000_1101, 0, 0); // SIPO, ser_in 1,0,1,1

    // Reset in the middle of RUN
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_cnt = 3'd5; cmd_din = 4'b0001;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      cmd_valid = 1'b0;
    end
    check("midrun_sel", sr_sel, 3'b100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("midrst_no_rsp", rsp_valid, 0);
    end

    do_cmd(3'b101, 3'd0, 4'b0110, 8'h00, 0, 1);   // cnt=0: preload only, early ready

    // Max count followed immediately by a second command
    do_cmd(3'b110, 3'd7, 4'b0001, 8'h00, 0, 1);
    a1 = last_acc;
    do_cmd(3'b111, 3'd3, 4'b0011, 8'h00, 0, 1);
    check("b2b_period", last_acc - a1, 7 + 4);

    for (int i = 0; i < 6; i++) begin
      bit e;
      e = 1'($urandom_range(1));
      do_cmd(3'($urandom_range(7)), 3'($urandom_range(7)), 4'($urandom), 8'($urandom),
             e ? 0 : $urandom_range(3), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
